// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace capture engine.
// Defining TRACE_TIMESTAMP_EN adds a timestamp field to every stored sample.
package trace_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int TS_W_DEFAULT = 16;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif

    function automatic int ADDR_W(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample RAM: one write port and one registered read port,
// written so that it maps onto block RAM.
module trace_ram
    import trace_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = ADDR_W(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the array has no reset branch; a reset on every word would stop it mapping to block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_capture.sv
// Trace capture engine: circular sample buffer with pre-trigger window and
// mask/polarity/edge trigger plus value comparator. Optional TRACE_TIMESTAMP_EN.
module trace_capture
    import trace_pkg::*;
#(
    parameter  int DATA_W   = 43,
    parameter  int DEPTH    = 1024,
    parameter  int NUM_TRIG = 3,
    parameter  int VAL_W    = 8,
    parameter  int TS_W     = TS_W_DEFAULT,
    localparam int AW       = ADDR_W(DEPTH),
    localparam int RD_W     = DATA_W + TS_EN * TS_W
) (
    input  logic                clk_72m,
    input  logic                bus_reset_n,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic [DATA_W-1:0]   probe_i,
    input  logic [NUM_TRIG-1:0] trig_bits_i,
    input  logic [VAL_W-1:0]    trig_val_i,
    input  logic [NUM_TRIG-1:0] cfg_mask,
    input  logic [NUM_TRIG-1:0] cfg_pol,
    input  logic                cfg_edge,
    input  logic                cfg_val_en,
    input  logic [VAL_W-1:0]    cfg_val,
    input  logic [AW-1:0]       cfg_pretrig,
    output logic [2:0]          state_o,
    output logic                done_o,
    output logic [AW-1:0]       trig_addr_o,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [RD_W-1:0]     rd_data_o
);

    localparam logic [AW-1:0] PRE_MAX = AW'(DEPTH - 2);

    state_t              r_state, w_next;
    logic [AW-1:0]       r_wr_ptr, r_cnt, r_pretrig, r_trig_addr;
    logic [NUM_TRIG-1:0] r_prev_bits;
    logic [AW-1:0]       w_pretrig, w_rd_phys;
    logic [NUM_TRIG-1:0] w_level, w_match;
    logic                w_trig, w_arm, w_we;
    logic [RD_W-1:0]     w_wdata;

    // Pre-trigger window is clamped so the trigger plus one post sample always fit.
    assign w_pretrig = (cfg_pretrig > PRE_MAX) ? PRE_MAX : cfg_pretrig;

    assign w_level = ~(trig_bits_i ^ cfg_pol);
    assign w_match = cfg_edge ? (w_level & (r_prev_bits ^ cfg_pol)) : w_level;
    assign w_trig  = (&(w_match | ~cfg_mask)) && (!cfg_val_en || (trig_val_i == cfg_val));

    assign w_arm = arm_i && !abort_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_we  = (r_state == PRE) || (r_state == WAIT) || (r_state == POST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        if (abort_i) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (arm_i) w_next = (w_pretrig == '0) ? WAIT : PRE;
                PRE:        if ((r_cnt + 1'b1) == r_pretrig) w_next = WAIT;
                WAIT:       if (w_trig) w_next = POST;
                POST:       if (r_cnt == AW'(1)) w_next = DONE;
                default:    w_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_72m or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_pretrig   <= '0;
            r_trig_addr <= '0;
            r_prev_bits <= '0;
        end else begin
            r_state     <= w_next;
            r_prev_bits <= trig_bits_i;
            if (w_arm) begin
                r_wr_ptr  <= '0;
                r_cnt     <= '0;
                r_pretrig <= w_pretrig;
            end else if (!abort_i) begin
                if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
                case (r_state)
                    PRE:  r_cnt <= r_cnt + 1'b1;
                    WAIT: if (w_trig) begin
                        r_trig_addr <= r_wr_ptr;
                        r_cnt       <= AW'(DEPTH - 1) - r_pretrig;
                    end
                    POST: r_cnt <= r_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk_72m or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            r_ts <= '0;
        end else if (w_arm) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_wdata = {r_ts, probe_i};
`else
    assign w_wdata = probe_i;
`endif

    // Logical index 0 is the oldest sample, pretrig entries before the trigger.
    assign w_rd_phys = r_trig_addr - r_pretrig + rd_addr_i;

    trace_ram #(
        .WIDTH (RD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk_72m),
        .rst_n   (bus_reset_n),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_phys),
        .o_rdata (rd_data_o)
    );

    assign state_o     = r_state;
    assign done_o      = (r_state == DONE);
    assign trig_addr_o = r_trig_addr;

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Parametrised on-chip trace capture engine that replaces the vendor analyzer core for MSX mapper/PSRAM debug.
- Samples a probe bus every clk_72m cycle into a circular buffer.
- Fires on a programmable multi-channel trigger: per-bit mask, polarity and level/edge, plus an optional value comparator, e.g. for check_fsm_counter_max.
- Preserves a programmable pre-trigger window; the buffer is read back through a synchronous port by the host/debug UART logic.

Parameters:
- DATA_W, 43: probe width, in bits.
- DEPTH, 1024: samples stored. Must be a power of 2, at least 4.
- NUM_TRIG, 3: single-bit trigger channels.
- VAL_W, 8: width of the value comparator input.
- TS_W, 16: timestamp width. Used only with TRACE_TIMESTAMP_EN.

Ports:
- clk_72m  in  1  system clock.
- bus_reset_n  in  1  asynchronous active-low reset.
- arm_i  in  1  single-cycle pulse; starts a capture.
- abort_i  in  1  single-cycle pulse; forces IDLE.
- probe_i  in  DATA_W  sampled data.
- trig_bits_i  in  NUM_TRIG  trigger channels.
- trig_val_i  in  VAL_W  value compared against cfg_val.
- cfg_mask  in  NUM_TRIG  1 = channel participates in the trigger.
- cfg_pol  in  NUM_TRIG  1 = high/rising; 0 = low/falling.
- cfg_edge  in  1  0 = level mode; 1 = edge mode.
- cfg_val_en  in  1  enables the value comparator.
- cfg_val  in  VAL_W  comparator match value.
- cfg_pretrig  in  log2(DEPTH)  pre-trigger sample count.
- state_o  in/out n/a: output, 3 bits, current FSM state.
- done_o  out  1  capture complete; buffer valid.
- trig_addr_o  out  log2(DEPTH)  physical address of the trigger sample.
- rd_addr_i  in  log2(DEPTH)  logical read index; 0 = oldest sample.
- rd_data_o  out  DATA_W (+TS_W)  read data.

Behaviour:
- Reset values: state IDLE; done_o 0; trig_addr_o 0; write pointer 0; rd_data_o 0. RAM contents are not reset.
- The same reset state applies when reset is asserted mid-capture.
- FSM states: IDLE, PRE, WAIT, POST, DONE.
- arm_i in IDLE or DONE:
  - clear done_o, write pointer and counters.
  - go to PRE, or straight to WAIT if cfg_pretrig == 0.
  - arm_i in any other state is ignored.
- Writes: in PRE, WAIT and POST, probe_i is written at the write pointer every cycle and the pointer increments, wrapping mod DEPTH.
- PRE: count written samples; when count reaches cfg_pretrig, go to WAIT. Triggers in PRE are ignored.
- cfg_pretrig is clamped to DEPTH-2, so at least the trigger sample plus one post sample are stored.
- Channel i matches when:
  - level mode: trig_bits_i[i] == cfg_pol[i].
  - edge mode: the previous cycle's bit != cfg_pol[i] and the current bit == cfg_pol[i].
  - The previous-value register updates in every state.
- Trigger condition:
  - every masked channel matches AND (!cfg_val_en OR trig_val_i == cfg_val).
  - With mask 0 and comparator disabled, the trigger fires on the first WAIT cycle.
- On the trigger cycle:
  - that cycle's sample is written.
  - trig_addr_o <= write pointer.
  - load post counter = DEPTH-1-cfg_pretrig; go to POST.
- POST:
  - write one sample per cycle and decrement the counter.
  - on the last write, go to DONE and assert done_o.
  - Total stored = exactly DEPTH samples.
- DONE: writes stop; done_o stays 1 until arm_i or abort_i.
- abort_i in any state: go to IDLE and clear done_o. RAM content is retained. abort_i has priority over arm_i in the same cycle.
- Read port:
  - physical address = (trig_addr_o - cfg_pretrig_latched + rd_addr_i) mod DEPTH.
  - cfg_pretrig is latched at arm.
  - rd_data_o is registered: 1-cycle latency.
  - Readable in any state; contents are meaningful only when done_o = 1.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- When defined:
  - a free-running TS_W-bit counter (reset 0, wraps) increments every cycle and is cleared on arm.
  - each RAM word stores {timestamp, probe_i}; rd_data_o is DATA_W+TS_W wide with the timestamp in the MSBs.
- When undefined: no counter; RAM width and rd_data_o are DATA_W.

Decomposition:
- Package trace_pkg holds:
  - the state enum: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
  - the ADDR_W function (log2).
  - the default TS_W constant.
- One sub-module, trace_ram: simple dual-port RAM (one write port, one registered read port), inferred as BSRAM, parametrised by width and depth.

Test Plan:
- Setup for all tests: DEPTH=16, pretrig=4, probe = free-running count starting at 0 on arm.
  1. Level trigger: mask=001, pol=001, trig_bits[0] rises when probe=10. Required: done_o after 11 more cycles; rd_addr 0..15 returns 6..21; trig sample at rd_addr 4 = 10.
  2. Edge mode: trig_bits[0] held high from arm. Required: no trigger until it falls and then rises again; the trigger sample is the rising cycle.
  3. Trigger asserted during PRE (probe=2). Required: ignored; next qualifying cycle triggers. Mask 0 with comparator off: triggers at probe=4.
  4. Comparator only: cfg_val_en=1, cfg_val=0x2A, trig_val ramps. Required: trigger at trig_val=0x2A; combined with mask=010, both conditions are required.
  5. abort_i in POST. Required: state IDLE, done_o 0. arm_i while in WAIT: ignored. Reset mid-POST: all outputs return to reset values.
  6. With TRACE_TIMESTAMP_EN: rd_data_o MSBs increment by 1 per logical address; the timestamp wraps at TS_W=4 after 15.
